// File: rtl/fx_mac_pkg.sv
// Purpose : shared types and constants for the fx_mac layer sequencer.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: seq_state_t (sequencer FSM states), MAC_DRAIN_CYC (MAC result delay
//           after the last valid operand pair).
package fx_mac_pkg;

    // Cycles between the last valid operand pair and the MAC's result pulse.
    localparam int MAC_DRAIN_CYC = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/fx_mac_seq_addr.sv
// Purpose : k / j / row-offset counters and the weight, data and output address adders.
// Latency : addresses are combinational from the counter registers (0 cycles).
// Backpr. : none; counters advance only on the sequencer's explicit strobes.
// Ports   : i_clk, i_rst (sync active-high); i_clr restarts a job, i_k_inc steps k
//           during fetch, i_row_next steps j and the row offset after each write;
//           i_*_base / i_n_out are the latched job config; o_k_last / o_row_last
//           flag loop ends; o_w_addr / o_d_addr / o_o_addr are the memory addresses.
module fx_mac_seq_addr #(
    parameter int K  = 4,
    parameter int AW = 10,
    parameter int NW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_k_inc,
    input  logic          i_row_next,
    input  logic [AW-1:0] i_w_base,
    input  logic [AW-1:0] i_d_base,
    input  logic [AW-1:0] i_o_base,
    input  logic [NW-1:0] i_n_out,
    output logic          o_k_last,
    output logic          o_row_last,
    output logic [AW-1:0] o_w_addr,
    output logic [AW-1:0] o_d_addr,
    output logic [AW-1:0] o_o_addr
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;

    logic [KW-1:0] r_k;
    logic [NW-1:0] r_j;
    logic [AW-1:0] r_off;     // running j*K, avoids a multiplier

    logic [AW-1:0] w_k_ext;
    logic [AW-1:0] w_j_ext;
    logic [NW:0]   w_j_plus1;

    assign w_k_ext   = AW'(r_k);
    assign w_j_ext   = AW'(r_j);
    // One extra bit so j+1 == n_out compares cleanly when n_out = 2^NW-1.
    assign w_j_plus1 = {1'b0, r_j} + (NW+1)'(1);

    assign o_k_last   = (r_k == KW'(K-1));
    assign o_row_last = (w_j_plus1 == {1'b0, i_n_out});

    // All sums wrap naturally modulo 2^AW.
    assign o_w_addr = i_w_base + r_off + w_k_ext;
    assign o_d_addr = i_d_base + w_k_ext;
    assign o_o_addr = i_o_base + w_j_ext;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_k   <= '0;
            r_j   <= '0;
            r_off <= '0;
        end else begin
            if (i_k_inc) begin
                r_k <= o_k_last ? '0 : r_k + KW'(1);
            end
            if (i_row_next) begin
                r_j   <= r_j + NW'(1);
                r_off <= r_off + AW'(K);
            end
        end
    end

endmodule

// File: rtl/fx_mac_seq.sv
// Purpose : fully-connected layer sequencer for one fx_mac: fetch K weight/data pairs per output,
//           wait for the MAC result, write it to output memory, repeat n_out times.
// Latency : K+8 cycles per output; start to done_o = n_out*(K+8)+2 cycles (2 when n_out = 0).
// Backpr. : none; the MAC and memories have fixed latency, DRAIN waits indefinitely for mac_vld_i.
// Ports   : clk_i, rst (sync active-high); start_i + cfg_* job request (sampled in IDLE only);
//           busy_o / done_o status; w_* and d_* sync-read memory ports (1-cycle latency);
//           mac_vld_o/mac_win_o/mac_din_o to the MAC, mac_acc_i/mac_vld_i from it;
//           o_we_o/o_addr_o/o_data_o output memory write port.
// Option  : define FX_MAC_SEQ_RELU_EN to clamp negative results to zero on write.
module fx_mac_seq
    import fx_mac_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 4,
    parameter int AW    = 10,
    parameter int NW    = 8
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             start_i,
    input  logic [AW-1:0]    cfg_w_base_i,
    input  logic [AW-1:0]    cfg_d_base_i,
    input  logic [AW-1:0]    cfg_o_base_i,
    input  logic [NW-1:0]    cfg_n_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             w_en_o,
    output logic [AW-1:0]    w_addr_o,
    input  logic [WIDTH-1:0] w_data_i,
    output logic             d_en_o,
    output logic [AW-1:0]    d_addr_o,
    input  logic [WIDTH-1:0] d_data_i,
    output logic             mac_vld_o,
    output logic [WIDTH-1:0] mac_win_o,
    output logic [WIDTH-1:0] mac_din_o,
    input  logic [WIDTH-1:0] mac_acc_i,
    input  logic             mac_vld_i,
    output logic             o_we_o,
    output logic [AW-1:0]    o_addr_o,
    output logic [WIDTH-1:0] o_data_o
);

    seq_state_t       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_mac_vld;
    logic [WIDTH-1:0] r_res;
    logic [AW-1:0]    r_w_base;
    logic [AW-1:0]    r_d_base;
    logic [AW-1:0]    r_o_base;
    logic [NW-1:0]    r_n_out;

    logic             w_fetch;
    logic             w_write;
    logic             w_accept;
    logic             w_k_last;
    logic             w_row_last;
    logic [AW-1:0]    w_w_addr;
    logic [AW-1:0]    w_d_addr;
    logic [AW-1:0]    w_o_addr;
    logic [WIDTH-1:0] w_res_out;

    assign w_fetch  = (r_state == ST_FETCH);
    assign w_write  = (r_state == ST_WRITE);
    assign w_accept = (r_state == ST_IDLE) && start_i;

    fx_mac_seq_addr #(
        .K  (K),
        .AW (AW),
        .NW (NW)
    ) u_addr (
        .i_clk      (clk_i),
        .i_rst      (rst),
        .i_clr      (w_accept),
        .i_k_inc    (w_fetch),
        .i_row_next (w_write),
        .i_w_base   (r_w_base),
        .i_d_base   (r_d_base),
        .i_o_base   (r_o_base),
        .i_n_out    (r_n_out),
        .o_k_last   (w_k_last),
        .o_row_last (w_row_last),
        .o_w_addr   (w_w_addr),
        .o_d_addr   (w_d_addr),
        .o_o_addr   (w_o_addr)
    );

`ifdef FX_MAC_SEQ_RELU_EN
    assign w_res_out = r_res[WIDTH-1] ? '0 : r_res;
`else
    assign w_res_out = r_res;
`endif

    // Memory requests are a direct decode of the FETCH state; addresses are
    // forced to zero when idle so the ports are quiet outside a fetch.
    assign w_en_o   = w_fetch;
    assign d_en_o   = w_fetch;
    assign w_addr_o = w_fetch ? w_w_addr : '0;
    assign d_addr_o = w_fetch ? w_d_addr : '0;

    // Read data arrives one cycle after the request, aligned with the delayed
    // enable, so the operands bypass any register and are gated by that enable.
    assign mac_vld_o = r_mac_vld;
    assign mac_win_o = r_mac_vld ? w_data_i : '0;
    assign mac_din_o = r_mac_vld ? d_data_i : '0;

    assign o_we_o   = w_write;
    assign o_addr_o = w_write ? w_o_addr  : '0;
    assign o_data_o = w_write ? w_res_out : '0;

    assign busy_o = r_busy;
    assign done_o = r_done;

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mac_vld <= 1'b0;
            r_res     <= '0;
            r_w_base  <= '0;
            r_d_base  <= '0;
            r_o_base  <= '0;
            r_n_out   <= '0;
        end else begin
            r_done    <= 1'b0;
            r_mac_vld <= w_fetch;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_w_base <= cfg_w_base_i;
                        r_d_base <= cfg_d_base_i;
                        r_o_base <= cfg_o_base_i;
                        r_n_out  <= cfg_n_out_i;
                        r_busy   <= 1'b1;
                        r_state  <= (cfg_n_out_i == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (w_k_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The MAC's own clear happens because its vld history is
                    // empty by the time we return to FETCH.
                    if (mac_vld_i) begin
                        r_res   <= mac_acc_i;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_state <= w_row_last ? ST_DONE : ST_FETCH;
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fx_mac_seq.sv
// Purpose : self-checking bench for fx_mac_seq with behavioural memories and a behavioural MAC.
// Latency : n/a.
// Backpr. : n/a.
module tb_fx_mac_seq;
    import fx_mac_pkg::*;

    localparam int WIDTH = 8;
    localparam int K     = 4;
    localparam int AW    = 10;
    localparam int NW    = 8;
    localparam int FRAC  = 4;
    localparam int MEMSZ = 1 << AW;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [AW-1:0]    wb = '0, db = '0, ob = '0;
    logic [NW-1:0]    nout = '0;
    logic             busy, done, w_en, d_en, mac_vld, o_we;
    logic [AW-1:0]    w_addr, d_addr, o_addr;
    logic [WIDTH-1:0] w_data = '0, d_data = '0, mac_win, mac_din, o_data;
    logic [WIDTH-1:0] mac_acc = '0;
    logic             mac_vld_in = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fx_mac_seq #(.WIDTH(WIDTH), .K(K), .AW(AW), .NW(NW)) dut (
        .clk_i        (clk),
        .rst          (rst),
        .start_i      (start),
        .cfg_w_base_i (wb),
        .cfg_d_base_i (db),
        .cfg_o_base_i (ob),
        .cfg_n_out_i  (nout),
        .busy_o       (busy),
        .done_o       (done),
        .w_en_o       (w_en),
        .w_addr_o     (w_addr),
        .w_data_i     (w_data),
        .d_en_o       (d_en),
        .d_addr_o     (d_addr),
        .d_data_i     (d_data),
        .mac_vld_o    (mac_vld),
        .mac_win_o    (mac_win),
        .mac_din_o    (mac_din),
        .mac_acc_i    (mac_acc),
        .mac_vld_i    (mac_vld_in),
        .o_we_o       (o_we),
        .o_addr_o     (o_addr),
        .o_data_o     (o_data)
    );

    // ---------------- helpers ----------------
    function automatic int sx8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Round half up at the fraction boundary, then saturate to signed WIDTH.
    function automatic logic [7:0] sat_round(input int s);
        int r;
        logic [31:0] rv;
        r = (s + (1 << (FRAC-1))) >>> FRAC;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        rv = r;
        return rv[7:0];
    endfunction

    // ---------------- behavioural memories ----------------
    logic [7:0] wmem [MEMSZ];
    logic [7:0] dmem [MEMSZ];
    int reads = 0;

    always @(posedge clk) begin
        if (w_en) w_data <= wmem[w_addr];
        if (d_en) d_data <= dmem[d_addr];
        if (w_en || d_en) reads = reads + 1;
    end

    int wqa[$];
    int wqd[$];
    int dones = 0;
    always @(posedge clk) begin
        if (o_we) begin
            wqa.push_back(int'(o_addr));
            wqd.push_back(int'(o_data));
        end
        if (done) dones = dones + 1;
    end

    // ---------------- behavioural MAC ----------------
    int  acc_sum = 0;
    int  since = 0;
    bit  pending = 0;
    always @(posedge clk) begin
        if (rst) begin
            acc_sum = 0;
            since   = 0;
            pending = 0;
            mac_vld_in <= 1'b0;
            mac_acc    <= '0;
        end else begin
            mac_vld_in <= 1'b0;
            if (mac_vld) begin
                acc_sum = acc_sum + sx8(mac_win) * sx8(mac_din);
                pending = 1;
                since   = 0;
            end else if (pending) begin
                since = since + 1;
                if (since == MAC_DRAIN_CYC - 1) begin
                    mac_vld_in <= 1'b1;
                    mac_acc    <= sat_round(acc_sum);
                    pending = 0;
                    acc_sum = 0;
                end
            end
        end
    end

    // ---------------- mac_vld burst monitor ----------------
    int run = 0, gap = 0;
    bit seen = 0;
    int bursts[$];
    int gaps[$];
    always @(posedge clk) begin
        if (mac_vld) begin
            if (run == 0 && seen) gaps.push_back(gap);
            run = run + 1;
        end else begin
            if (run > 0) begin
                bursts.push_back(run);
                run  = 0;
                seen = 1;
                gap  = 0;
            end
            gap = gap + 1;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_out(input int wbi, input int dbi, input int j);
        int s;
        logic [7:0] r;
        s = 0;
        for (int k = 0; k < K; k++)
            s += sx8(wmem[(wbi + j*K + k) % MEMSZ]) * sx8(dmem[(dbi + k) % MEMSZ]);
        r = sat_round(s);
`ifdef FX_MAC_SEQ_RELU_EN
        if (r[7]) r = 8'h00;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_row(input int wbi, input int j, input logic [7:0] v);
        for (int k = 0; k < K; k++) wmem[(wbi + j*K + k) % MEMSZ] = v;
    endtask

    task automatic fill_data(input int dbi, input logic [7:0] v);
        for (int k = 0; k < K; k++) dmem[(dbi + k) % MEMSZ] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < MEMSZ; i++) begin
            wmem[i] = 8'($urandom);
            dmem[i] = 8'($urandom);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(done), 0);
        check({tag, "_en"},    32'({w_en, d_en, mac_vld, o_we}), 0);
        check({tag, "_addr"},  32'({w_addr, d_addr, o_addr}), 0);
        check({tag, "_data"},  32'({mac_win, mac_din, o_data}), 0);
    endtask

    // Runs one job; optionally issues a second start while busy.
    task automatic run_job(input string tag, input int wbi, input int dbi, input int obi,
                           input int n, input bit dbl_start);
        int w0, b0, g0, r0, cyc, bound, lat, nw;
        bit got;
        w0 = wqa.size(); b0 = bursts.size(); g0 = gaps.size(); r0 = reads;
        bound = n*(K+8) + 40;
        @(negedge clk);
        wb = AW'(wbi); db = AW'(dbi); ob = AW'(obi); nout = NW'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy1"}, 32'(busy), 1);
        got = 0;
        while (cyc < bound) begin
            if (done) begin
                got = 1;
                break;
            end
            if (dbl_start && cyc == 3) begin
                start = 1'b1;
                wb = AW'(wbi + 100); ob = AW'(obi + 50); nout = NW'(n + 3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        lat = got ? cyc : -1;
        check({tag, "_latency"}, 32'(lat), 32'(n*(K+8) + 2));
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 0);
        nw = wqa.size() - w0;
        check({tag, "_nwrites"}, 32'(nw), 32'(n));
        for (int i = 0; i < n && i < nw; i++) begin
            check({tag, "_waddr"}, 32'(wqa[w0+i]), 32'((obi + i) % MEMSZ));
            check({tag, "_wdata"}, 32'(wqd[w0+i]), 32'(ref_out(wbi, dbi, i)));
        end
        check({tag, "_nbursts"}, 32'(bursts.size() - b0), 32'(n));
        for (int i = b0; i < bursts.size(); i++)
            check({tag, "_burstlen"}, 32'(bursts[i]), K);
        if (n >= 2) begin
            for (int i = gaps.size() - (n-1); i < gaps.size(); i++)
                if (i >= g0) check({tag, "_gap"}, 32'(gaps[i]), 8);
        end
        if (n == 0) check({tag, "_noreads"}, 32'(reads - r0), 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int d0, w0;
        fill_random();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_quiet("idle");

        // Single output: 4 x (1.0*1.0) = 4.0 -> 0x40.
        fill_row(0, 0, 8'h10); fill_data(16, 8'h10);
        run_job("one", 0, 16, 32, 1, 0);
        check("one_val", 32'(ref_out(0, 16, 0)), 32'h40);

        // Three rows: 1.0, 0.5, -1.0 against data 1.0.
        fill_row(64, 0, 8'h10); fill_row(64, 1, 8'h08); fill_row(64, 2, 8'hF0);
        fill_data(80, 8'h10);
        run_job("three", 64, 80, 96, 3, 0);

        // Saturation both ways.
        fill_row(128, 0, 8'h70); fill_data(136, 8'h70);
        run_job("satpos", 128, 136, 140, 1, 0);
        fill_data(136, 8'h90);
        run_job("satneg", 128, 136, 141, 1, 0);

        // Zero outputs.
        run_job("zero", 5, 6, 7, 0, 0);

        // Second start while busy is ignored.
        fill_random();
        run_job("dbl", 200, 300, 400, 2, 1);

        // Weight base wraps past the top of memory.
        run_job("wrap", 10'h3FE, 10'h3FD, 10'h3FF, 3, 0);

        // Largest n_out.
        run_job("max", 17, 500, 600, 255, 0);

        // Random jobs.
        for (int t = 0; t < 6; t++)
            run_job("rand", int'($urandom_range(0, MEMSZ-1)), int'($urandom_range(0, MEMSZ-1)),
                    int'($urandom_range(0, MEMSZ-1)), int'($urandom_range(1, 6)), 0);

        // Reset during DRAIN: nothing must follow, then a fresh job is correct.
        @(negedge clk);
        wb = 10'd20; db = 10'd40; ob = 10'd60; nout = 8'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_quiet("rstdrain");
        rst = 1'b0;
        d0 = dones; w0 = wqa.size();
        repeat (30) @(posedge clk);
        #1;
        check("rstdrain_nowrite", 32'(wqa.size() - w0), 0);
        check("rstdrain_nodone", 32'(dones - d0), 0);
        run_job("after_rst", 20, 40, 60, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
